// File: rtl/led_pattern_arbiter_if.sv
// -----------------------------------------------------------------------------
// led_pattern_arbiter_if
//   Bundles the requester-facing and LED-facing signals of led_pattern_arbiter.
//   Signals:
//     req   [N_REQ-1:0]    request per requester, level-held
//     mode  [2*N_REQ-1:0]  2-bit pattern per requester (00 off, 01 on, 10 slow, 11 fast)
//     led                  registered LED drive
//     grant [N_REQ-1:0]    registered one-hot owner, zero when idle
//     tick                 one-cycle prescaler pulse
//   Modports:
//     master  status sources / board top (drives req, mode)
//     slave   the arbiter itself (drives led, grant, tick)
// -----------------------------------------------------------------------------
interface led_pattern_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req;
   logic [2*N_REQ-1:0] mode;
   logic               led;
   logic [N_REQ-1:0]   grant;
   logic               tick;

   modport master (output req, output mode, input led, input grant, input tick);
   modport slave  (input req, input mode, output led, output grant, output tick);
endinterface

// File: rtl/led_pattern_arbiter.sv
// -----------------------------------------------------------------------------
// led_pattern_arbiter
//   Shares the single board LED among N_REQ requesters. Each requester asks for
//   off, solid on, slow blink or fast blink. A built-in prescaler produces a
//   tick every TICK_DIV clocks; arbitration and blink phase advance happen only
//   on ticks. Everything is held idle while the clock wizard is not locked.
//
//   Ports:
//     clk         system clock from the clock wizard
//     rst_n       asynchronous active-low reset
//     pll_locked  clock wizard locked; low clears the block on the next edge
//     bus         led_pattern_arbiter_if.slave (req, mode in; led, grant, tick out)
//
//   Configuration macro:
//     ROUND_ROBIN_EN  undefined: fixed priority, index 0 highest, owner can be
//                     preempted by a higher-priority request.
//                     defined: round robin without preemption; the search starts
//                     at the index after the last owner.
// -----------------------------------------------------------------------------
module led_pattern_arbiter #(
   parameter int N_REQ     = 4,
   parameter int TICK_DIV  = 4000,
   parameter int SLOW_HALF = 5000,
   parameter int FAST_HALF = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pll_locked,
   led_pattern_arbiter_if.slave bus
);

   localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PW       = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
   localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {
      IDLE,
      SERVE
   } state_e;

   state_e            state_q, state_d;
   logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
   logic [PW-1:0]     phase_cnt_q, phase_cnt_d;
   logic              blink_ph_q, blink_ph_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic              led_q, led_d;
`ifdef ROUND_ROBIN_EN
   logic [IW-1:0]     last_q, last_d;
`endif

   logic              tick_w;
   logic              win_found;
   logic [IW-1:0]     win_idx;
   logic              owner_req;
   logic [1:0]        owner_mode;
   logic [1:0]        next_mode;
   logic [PW-1:0]     half_m1;

   // Prescaler: ticks are suppressed while unlocked so nothing downstream can
   // advance on a stale count during the clearing edge.
   always_comb begin
      tick_w     = pll_locked && (tick_cnt_q == TW'(TICK_DIV - 1));
      tick_cnt_d = tick_w ? '0 : tick_cnt_q + 1'b1;
      if (!pll_locked) begin
         tick_cnt_d = '0;
      end
   end

   // Winner selection over the current request vector.
   always_comb begin : winner_sel
`ifdef ROUND_ROBIN_EN
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(last_q) + 1 + k) % N_REQ;
         if (!win_found && bus.req[idx]) begin
            win_found = 1'b1;
            win_idx   = IW'(idx);
         end
      end
`else
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.req[k]) begin
            win_found = 1'b1;
            win_idx   = IW'(k);
         end
      end
`endif
   end

   // Current owner's request and mode; the mode decides the blink half-period.
   always_comb begin
      owner_req  = bus.req[owner_q];
      owner_mode = 2'b00;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == IW'(i)) begin
            owner_mode = bus.mode[2*i +: 2];
         end
      end
      half_m1 = owner_mode[0] ? PW'(FAST_HALF - 1) : PW'(SLOW_HALF - 1);
   end

   // Next-state logic. The phase wrap uses >= so that switching from a long
   // to a short half-period with phase_cnt already past the new end wraps on
   // the very next tick instead of running on to the counter limit.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      phase_cnt_d = phase_cnt_q;
      blink_ph_d  = blink_ph_q;
`ifdef ROUND_ROBIN_EN
      last_d      = last_q;
`endif
      if (!pll_locked) begin
         state_d     = IDLE;
         phase_cnt_d = '0;
         blink_ph_d  = 1'b1;
      end else if (tick_w) begin
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  state_d     = SERVE;
                  owner_d     = win_idx;
                  phase_cnt_d = '0;
                  blink_ph_d  = 1'b1;
`ifdef ROUND_ROBIN_EN
                  last_d      = win_idx;
`endif
               end
            end
            SERVE: begin
               if (!owner_req) begin
                  if (win_found) begin
                     owner_d     = win_idx;
                     phase_cnt_d = '0;
                     blink_ph_d  = 1'b1;
`ifdef ROUND_ROBIN_EN
                     last_d      = win_idx;
`endif
                  end else begin
                     state_d = IDLE;
                  end
`ifndef ROUND_ROBIN_EN
               end else if (win_idx != owner_q) begin
                  owner_d     = win_idx;
                  phase_cnt_d = '0;
                  blink_ph_d  = 1'b1;
`endif
               end else if (owner_mode[1]) begin
                  if (phase_cnt_q >= half_m1) begin
                     phase_cnt_d = '0;
                     blink_ph_d  = ~blink_ph_q;
                  end else begin
                     phase_cnt_d = phase_cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Registered outputs follow the next state so that a new grant shows its
   // pattern on the same edge; the mode is re-read every clock.
   always_comb begin
      grant_d   = '0;
      led_d     = 1'b0;
      next_mode = 2'b00;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_d == IW'(i)) begin
            next_mode = bus.mode[2*i +: 2];
         end
      end
      if (state_d == SERVE) begin
         grant_d[owner_d] = 1'b1;
         case (next_mode)
            2'b00:   led_d = 1'b0;
            2'b01:   led_d = 1'b1;
            default: led_d = blink_ph_d;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         phase_cnt_q <= '0;
         blink_ph_q  <= 1'b1;
         owner_q     <= '0;
         grant_q     <= '0;
         led_q       <= 1'b0;
`ifdef ROUND_ROBIN_EN
         last_q      <= IW'(N_REQ - 1);
`endif
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         phase_cnt_q <= phase_cnt_d;
         blink_ph_q  <= blink_ph_d;
         owner_q     <= owner_d;
         grant_q     <= grant_d;
         led_q       <= led_d;
`ifdef ROUND_ROBIN_EN
         last_q      <= last_d;
`endif
      end
   end

   assign bus.led   = led_q;
   assign bus.grant = grant_q;
   assign bus.tick  = tick_w;

endmodule
